posit_mul_decoded_8bit: RTL and testbench



---
 rtl/posit_mul_decoded_8bit.sv | 128 ++++++++++++
 tb/tb_posit_mul_decoded_8bit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/posit_mul_decoded_8bit.sv
// Two-stage multiplier for 8-bit posits in the 12-bit decoded format
// ({INF, ZER, SGN, EXP[3:0], FRAC[4:0]}); rounds to nearest-even and clamps to maxpos/minpos.
module posit_mul_decoded_8bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_a,
  input  logic [11:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_dposit,
  output logic        out_sat
);

  localparam logic [11:0] NAR  = 12'h800;
  localparam logic [11:0] ZERO = 12'h400;

  logic        r_s1_valid;
  logic        r_s1_inf;
  logic        r_s1_zer;
  logic        r_s1_sgn;
  logic [5:0]  r_s1_exp;
  logic [11:0] r_s1_prod;

  logic        r_out_valid;
  logic [11:0] r_out_dposit;
  logic        r_out_sat;

  logic        w_s2_free;
  logic [5:0]  w_mant_a;
  logic [5:0]  w_mant_b;
  logic [11:0] w_prod;
  logic [5:0]  w_exp_sum;

  assign w_s2_free = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_free;

  assign w_mant_a  = {1'b1, in_a[4:0]};
  assign w_mant_b  = {1'b1, in_b[4:0]};
  assign w_prod    = {6'd0, w_mant_a} * {6'd0, w_mant_b};
  assign w_exp_sum = {2'b00, in_a[8:5]} + {2'b00, in_b[8:5]} - 6'd7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_zer   <= 1'b0;
      r_s1_sgn   <= 1'b0;
      r_s1_exp   <= 6'd0;
      r_s1_prod  <= 12'd0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_inf  <= in_a[11] | in_b[11];
        r_s1_zer  <= in_a[10] | in_b[10];
        r_s1_sgn  <= in_a[9] ^ in_b[9];
        r_s1_exp  <= w_exp_sum;
        r_s1_prod <= w_prod;
      end
    end
  end

  // Stage 2: normalize, round-to-nearest-even, then saturate on the post-round exponent.
  logic [5:0]        w_exp_norm;
  logic [4:0]        w_frac_raw;
  logic              w_guard;
  logic              w_sticky;
  logic              w_round_up;
  logic [5:0]        w_frac_inc;
  logic signed [5:0] w_exp_rnd;
  logic [11:0]       w_result;
  logic              w_sat;

  always_comb begin
    w_exp_norm = r_s1_exp + {5'd0, r_s1_prod[11]};
    w_frac_raw = 5'd0;
    w_guard    = 1'b0;
    w_sticky   = 1'b0;
    if (r_s1_prod[11]) begin
      w_frac_raw = r_s1_prod[10:6];
      w_guard    = r_s1_prod[5];
      w_sticky   = |r_s1_prod[4:0];
    end else begin
      w_frac_raw = r_s1_prod[9:5];
      w_guard    = r_s1_prod[4];
      w_sticky   = |r_s1_prod[3:0];
    end
    w_round_up = w_guard & (w_sticky | w_frac_raw[0]);
    w_frac_inc = {1'b0, w_frac_raw} + {5'd0, w_round_up};
    w_exp_rnd  = w_exp_norm + {5'd0, w_frac_inc[5]};

    w_result = 12'd0;
    w_sat    = 1'b0;
    if (r_s1_inf) begin
      w_result = NAR;
    end else if (r_s1_zer) begin
      w_result = ZERO;
    end else if (w_exp_rnd > 6'sd13) begin
      w_result = {2'b00, r_s1_sgn, 4'd13, 5'd0};
      w_sat    = 1'b1;
    end else if (w_exp_rnd < 6'sd1) begin
      w_result = {2'b00, r_s1_sgn, 4'd1, 5'd0};
      w_sat    = 1'b1;
    end else begin
      w_result = {2'b00, r_s1_sgn, w_exp_rnd[3:0], w_frac_inc[4:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_dposit <= 12'd0;
      r_out_sat    <= 1'b0;
    end else if (w_s2_free) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_dposit <= w_result;
        r_out_sat    <= w_sat;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_dposit = r_out_dposit;
  assign out_sat    = r_out_sat;

endmodule

// File: tb/tb_posit_mul_decoded_8bit.sv
// Directed bench for posit_mul_decoded_8bit: arithmetic vectors, backpressure, async reset.
module tb_posit_mul_decoded_8bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_dposit;
  logic        out_sat;

  int errors = 0;
  int checks = 0;

  posit_mul_decoded_8bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_dposit (out_dposit),
    .out_sat    (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One isolated operation: accept, confirm nothing out after 1 cycle, result after 2.
  task automatic run_op(input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] exp_d, input logic exp_s, input string tag);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, {12'd0, in_ready}, 13'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check({tag, "_early_valid"}, {12'd0, out_valid}, 13'd0);
    @(negedge clk);
    #1;
    check({tag, "_valid"}, {12'd0, out_valid}, 13'd1);
    check({tag, "_dposit"}, {1'b0, out_dposit}, {1'b0, exp_d});
    check({tag, "_sat"}, {12'd0, out_sat}, {12'd0, exp_s});
  endtask

  logic [11:0] bp_a   [5] = '{12'h0F0, 12'h100, 12'h0E0, 12'h0F0, 12'h0E1};
  logic [11:0] bp_b   [5] = '{12'h0E0, 12'h100, 12'h2F0, 12'h0F0, 12'h0F0};
  logic [11:0] bp_exp [5] = '{12'h0F0, 12'h120, 12'h2F0, 12'h104, 12'h0F2};
  logic        bp_rdy [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  int          idx;
  int          got;
  logic        stalled;
  logic [12:0] held;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = 12'd0; in_b = 12'd0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", {12'd0, out_valid}, 13'd0);
    check("rst_out_dposit", {1'b0, out_dposit}, 13'd0);
    check("rst_out_sat", {12'd0, out_sat}, 13'd0);
    check("rst_in_ready", {12'd0, in_ready}, 13'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(12'h0E0, 12'h0E0, 12'h0E0, 1'b0, "one_x_one");
    run_op(12'h0F0, 12'h0F0, 12'h104, 1'b0, "1p5_x_1p5");
    run_op(12'h2E0, 12'h0E0, 12'h2E0, 1'b0, "neg1_x_1");
    run_op(12'h2F0, 12'h2E0, 12'h0F0, 1'b0, "neg_x_neg");
    run_op(12'h0E1, 12'h0F0, 12'h0F2, 1'b0, "tie_even_up");
    run_op(12'h0E1, 12'h0E1, 12'h0E2, 1'b0, "round_down");
    run_op(12'h0E8, 12'h0F3, 12'h100, 1'b0, "round_carry");
    run_op(12'h1A0, 12'h1A0, 12'h1A0, 1'b1, "sat_max");
    run_op(12'h020, 12'h020, 12'h020, 1'b1, "sat_min");
    run_op(12'h3A0, 12'h1A0, 12'h3A0, 1'b1, "sat_neg_max");
    run_op(12'h1A0, 12'h0E0, 12'h1A0, 1'b0, "exp13_edge");
    run_op(12'h020, 12'h0E0, 12'h020, 1'b0, "exp1_edge");
    run_op(12'h800, 12'h400, 12'h800, 1'b0, "inf_x_zero");
    run_op(12'h400, 12'h0E0, 12'h400, 1'b0, "zero_x_one");
    run_op(12'h800, 12'h0E0, 12'h800, 1'b0, "inf_x_one");
    run_op(12'hC00, 12'h0E0, 12'h800, 1'b0, "malformed_inf");

    // Backpressure: 5 back-to-back pairs, out_ready low on cycles 1..4 of this sequence.
    idx = 0; got = 0; stalled = 1'b0; held = 13'd0;
    for (int c = 0; c < 16 && got < 5; c++) begin
      @(negedge clk);
      out_ready = !(c >= 1 && c <= 4);
      in_valid  = (idx < 5);
      in_a      = (idx < 5) ? bp_a[idx] : 12'd0;
      in_b      = (idx < 5) ? bp_b[idx] : 12'd0;
      #1;
      if (c < 10) check($sformatf("bp_in_ready_c%0d", c), {12'd0, in_ready}, {12'd0, bp_rdy[c]});
      if (out_valid && stalled) check($sformatf("bp_stable_c%0d", c), {out_sat, out_dposit}, held);
      if (out_valid && out_ready) begin
        check($sformatf("bp_result_%0d", got), {out_sat, out_dposit}, {1'b0, bp_exp[got]});
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = {out_sat, out_dposit};
      if (in_valid && in_ready) idx++;
    end
    check("bp_all_results", got[12:0], 13'd5);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Async reset with two results in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 12'h0E0; in_b = 12'h0E0;
    @(negedge clk);
    in_a = 12'h0F0; in_b = 12'h0F0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_inflight", {12'd0, out_valid}, 13'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {12'd0, out_valid}, 13'd0);
    check("async_rst_dposit", {1'b0, out_dposit}, 13'd0);
    check("async_rst_in_ready", {12'd0, in_ready}, 13'd1);
    @(negedge clk);
    #1;
    check("rst_held_in_ready", {12'd0, in_ready}, 13'd1);
    rst_n = 1'b1;
    run_op(12'h0F0, 12'h0E0, 12'h0F0, 1'b0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
